// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator bank: reference clock rate and
// default half-period values, plus a helper for the channel-select width.
package tick_gen_pkg;

    localparam int TG_CLK_HZ     = 100_000_000;
    localparam int TG_HALF_2HZ   = 25_000_000;
    localparam int TG_HALF_1HZ   = 50_000_000;
    localparam int TG_HALF_FAST  = 125_000;
    localparam int TG_HALF_BLINK = 1_250_000;

    // A single-channel bank still needs a 1-bit select so the load port exists.
    function automatic int tg_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_bank_if.sv
// Half-period load bus: request (valid/channel/value), ready back-pressure
// and the one-cycle reject pulse.
interface tick_gen_bank_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
) ();
    import tick_gen_pkg::*;

    localparam int CH_W = tg_ch_w(N_CH);

    logic             ld_valid;
    logic [CH_W-1:0]  ld_ch;
    logic [CNT_W-1:0] ld_half;
    logic             ld_ready;
    logic             ld_err;

    modport master (
        output ld_valid, ld_ch, ld_half,
        input  ld_ready, ld_err
    );

    modport slave (
        input  ld_valid, ld_ch, ld_half,
        output ld_ready, ld_err
    );

endinterface

// File: rtl/tick_channel.sv
// One divider channel: half-period counter, active half-period, one-deep
// pending load slot, registered square wave and tick pulse.
module tick_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             ld_set,
    input  logic [CNT_W-1:0] ld_half,
    input  logic [CNT_W-1:0] def_half,
    output logic             tick,
    output logic             sq,
    output logic             pend_v
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] pend_h;
    logic             term;

    assign term = (cnt == h - CNT_W'(1));

    // A pending value is only swapped in at a period boundary (terminal count,
    // sync) or while frozen, so a running output never sees a shortened half.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            h      <= def_half;
            pend_v <= 1'b0;
            pend_h <= '0;
            sq     <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sync) begin
                cnt <= '0;
                sq  <= 1'b0;
                if (pend_v) begin
                    h      <= pend_h;
                    pend_v <= 1'b0;
                end
            end else if (!en) begin
                if (pend_v) begin
                    h      <= pend_h;
                    cnt    <= '0;
                    pend_v <= 1'b0;
                end
            end else if (term) begin
                cnt  <= '0;
                sq   <= ~sq;
                tick <= 1'b1;
                if (pend_v) begin
                    h      <= pend_h;
                    pend_v <= 1'b0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // Comes last so a load taken alongside sync or terminal count waits
            // for the next boundary instead of being consumed now.
            if (ld_set) begin
                pend_v <= 1'b1;
                pend_h <= ld_half;
            end
        end
    end

endmodule

// File: rtl/tick_gen_bank.sv
// Bank of N_CH independent tick/square-wave dividers sharing one load bus
// with range checking and a registered reject pulse.
module tick_gen_bank
    import tick_gen_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter logic [N_CH*CNT_W-1:0] DEF_HALF = (N_CH*CNT_W)'({
        CNT_W'(TG_HALF_BLINK), CNT_W'(TG_HALF_FAST),
        CNT_W'(TG_HALF_1HZ),   CNT_W'(TG_HALF_2HZ)})
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   en,
    input  logic              sync,
    tick_gen_bank_if.slave    ld,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   sq
);

    localparam int CH_W = tg_ch_w(N_CH);

    logic [N_CH-1:0] pend_v;
    logic [N_CH-1:0] ld_set;
    logic            pend_sel;
    logic            ch_ok;
    logic            accept;
    logic            reject;

    always_comb begin
        pend_sel = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ld.ld_ch == CH_W'(i)) pend_sel = pend_v[i];
        end
    end

    assign ch_ok       = int'(ld.ld_ch) < N_CH;
    assign ld.ld_ready = ~pend_sel & ~reset;
    assign accept      = ld.ld_valid & ld.ld_ready;
    assign reject      = (ld.ld_half == '0) | ~ch_ok;

    // Rejected loads leave every channel untouched; only the error pulse fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld.ld_err <= 1'b0;
        end else begin
            ld.ld_err <= accept & reject;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ld_set[i] = accept & ~reject & (ld.ld_ch == CH_W'(i));

        tick_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[i]),
            .sync     (sync),
            .ld_set   (ld_set[i]),
            .ld_half  (ld.ld_half),
            .def_half (DEF_HALF[i*CNT_W +: CNT_W]),
            .tick     (tick[i]),
            .sq       (sq[i]),
            .pend_v   (pend_v[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_bank.sv
// Scoreboard bench for tick_gen_bank: a countdown-based reference model
// predicts each cycle's outputs; a separate monitor compares them.
module tb_tick_gen_bank;

    localparam int N = 4;
    localparam int W = 8;
    localparam logic [N*W-1:0] DEFH = {8'd4, 8'd3, 8'd2, 8'd1};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sync = 1'b0;
    logic [N-1:0] en = '0;
    logic [N-1:0] tick;
    logic [N-1:0] sq;

    tick_gen_bank_if #(.N_CH(N), .CNT_W(W)) ld_bus ();

    tick_gen_bank #(.N_CH(N), .CNT_W(W), .DEF_HALF(DEFH)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .sync  (sync),
        .ld    (ld_bus),
        .tick  (tick),
        .sq    (sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] tick;
        logic [N-1:0] sq;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: cycles left until the next toggle, plus a queue of waiting loads.
    int           h_m[N];
    int           left_m[N];
    logic [N-1:0] sq_m;
    int           pend_q[N][$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < N; i++) begin
            h_m[i]    = int'(DEFH[i*W +: W]);
            left_m[i] = h_m[i];
            pend_q[i].delete();
        end
        sq_m = '0;
    endtask

    task automatic applyStimulus(input logic [N-1:0] e, input logic s, input logic v,
                                 input logic [1:0] c, input logic [W-1:0] hf, input logic r);
        exp_t x;
        logic rdy;
        logic acc;
        @(negedge clk);
        en              = e;
        sync            = s;
        reset           = r;
        ld_bus.ld_valid = v;
        ld_bus.ld_ch    = c;
        ld_bus.ld_half  = hf;
        #1;
        rdy = !r && (pend_q[c].size() == 0);
        checkOutput("ld_ready", 32'(ld_bus.ld_ready), 32'(rdy));
        acc   = v && rdy;
        x.tick = '0;
        x.err  = 1'b0;
        if (r) begin
            resetModel();
        end else begin
            x.err = acc && (hf == 0);
            for (int i = 0; i < N; i++) begin
                if (s) begin
                    if (pend_q[i].size() > 0) h_m[i] = pend_q[i].pop_front();
                    left_m[i] = h_m[i];
                    sq_m[i]   = 1'b0;
                end else if (!e[i]) begin
                    if (pend_q[i].size() > 0) begin
                        h_m[i]    = pend_q[i].pop_front();
                        left_m[i] = h_m[i];
                    end
                end else begin
                    left_m[i]--;
                    if (left_m[i] == 0) begin
                        x.tick[i] = 1'b1;
                        sq_m[i]   = ~sq_m[i];
                        if (pend_q[i].size() > 0) h_m[i] = pend_q[i].pop_front();
                        left_m[i] = h_m[i];
                    end
                end
            end
            if (acc && hf != 0) pend_q[c].push_back(int'(hf));
        end
        x.sq = sq_m;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput("tick", 32'(tick), 32'(x.tick));
                checkOutput("sq", 32'(sq), 32'(x.sq));
                checkOutput("ld_err", 32'(ld_bus.ld_err), 32'(x.err));
            end
        end
    end

    initial begin : stim
        logic [N-1:0] e;
        int           waited;
        ld_bus.ld_valid = 1'b0;
        ld_bus.ld_ch    = '0;
        ld_bus.ld_half  = '0;
        resetModel();

        $display("[TB] reset and free-run");
        repeat (2) applyStimulus(4'h0, 0, 0, 2'd0, 8'd0, 1);
        repeat (22) applyStimulus(4'hF, 0, 0, 2'd0, 8'd0, 0);

        $display("[TB] glitch-free reload of ch2");
        applyStimulus(4'hF, 0, 1, 2'd2, 8'd5, 0);
        applyStimulus(4'hF, 0, 1, 2'd2, 8'd7, 0);
        repeat (15) applyStimulus(4'hF, 0, 0, 2'd0, 8'd0, 0);

        $display("[TB] rejected zero load on ch1");
        applyStimulus(4'hF, 0, 1, 2'd1, 8'd0, 0);
        repeat (6) applyStimulus(4'hF, 0, 0, 2'd0, 8'd0, 0);

        $display("[TB] sync and enable gap");
        applyStimulus(4'hF, 1, 0, 2'd0, 8'd0, 0);
        repeat (10) applyStimulus(4'hF, 0, 0, 2'd0, 8'd0, 0);
        repeat (7) applyStimulus(4'b1101, 0, 0, 2'd0, 8'd0, 0);
        repeat (10) applyStimulus(4'hF, 0, 0, 2'd0, 8'd0, 0);

        $display("[TB] reset with pending load");
        applyStimulus(4'hF, 0, 1, 2'd2, 8'd6, 0);
        applyStimulus(4'hF, 0, 0, 2'd0, 8'd0, 1);
        repeat (12) applyStimulus(4'hF, 0, 0, 2'd0, 8'd0, 0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 1500; k++) begin
            e = '1;
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(7) == 0) e[j] = 1'b0;
            end
            applyStimulus(e, $urandom_range(31) == 0, $urandom_range(3) == 0,
                          2'($urandom_range(3)), 8'($urandom_range(6)),
                          $urandom_range(63) == 0);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 4) begin
            @(posedge clk);
            #2;
            waited++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
